// File: rtl/pe_input_port_if.sv
// Handshake bundle between the PE, the input buffer and the crossbar.
// Latency: none, this is a signal bundle only.
// Backpressure: flit_out_ready from the crossbar; the PE is paced by credit_out.
//   master : the environment side (PE + crossbar); drives flit_in, flit_in_valid, flit_out_ready
//   slave  : the input port; drives credit_out, flit_out, flit_out_valid, route_out, count
//   ovf    : present only when PE_INPUT_PORT_OVF_DETECT_EN is defined
interface pe_input_port_if;
    logic [19:0] flit_in;
    logic        flit_in_valid;
    logic        credit_out;
    logic [19:0] flit_out;
    logic        flit_out_valid;
    logic        flit_out_ready;
    logic [4:0]  route_out;
    logic [2:0]  count;
`ifdef PE_INPUT_PORT_OVF_DETECT_EN
    logic        ovf;
`endif

    modport master (
        output flit_in, flit_in_valid, flit_out_ready,
`ifdef PE_INPUT_PORT_OVF_DETECT_EN
        input  ovf,
`endif
        input  credit_out, flit_out, flit_out_valid, route_out, count
    );

    modport slave (
        input  flit_in, flit_in_valid, flit_out_ready,
`ifdef PE_INPUT_PORT_OVF_DETECT_EN
        output ovf,
`endif
        output credit_out, flit_out, flit_out_valid, route_out, count
    );
endinterface

// File: rtl/pe_input_port.sv
// PE-side input buffer of a mesh router: circular flit FIFO with XY route lookup of the head flit.
// Latency: push to flit_out is one cycle (no bypass); head flit, valid and route are combinational.
// Backpressure: crossbar stalls via flit_out_ready; each pop returns one credit to the PE a cycle later;
//               a push into a full buffer without a same-cycle pop is dropped.
// Ports: clk, RST (async active-low), p (pe_input_port_if.slave: flit_in/flit_in_valid,
//        credit_out, flit_out/flit_out_valid/flit_out_ready, route_out, count[, ovf]).
// Optional: define PE_INPUT_PORT_OVF_DETECT_EN to add the sticky ovf drop flag.
module pe_input_port #(
    parameter int DEPTH = 4,
    parameter int X_ID  = 0,
    parameter int Y_ID  = 0
) (
    input logic            clk,
    input logic            RST,
    pe_input_port_if.slave p
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] XC = 2'(X_ID);
    localparam logic [1:0] YC = 2'(Y_ID);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef struct packed {
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [15:0] payload;
    } flit_t;

    logic [19:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    cnt;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    flit_t         head;

    assign empty = (cnt == 3'd0);
    assign full  = (cnt == 3'(DEPTH));
    assign pop   = !empty && p.flit_out_ready;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign push  = p.flit_in_valid && (!full || pop);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            p.credit_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            p.credit_out <= pop;
        end
    end

    // Storage is deliberately not reset; entries are only visible while cnt != 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= p.flit_in;
    end

`ifdef PE_INPUT_PORT_OVF_DETECT_EN
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            p.ovf <= 1'b0;
        end else if (p.flit_in_valid && full && !pop) begin
            p.ovf <= 1'b1;
        end
    end
`endif

    assign head             = flit_t'(mem[rd_ptr]);
    assign p.flit_out       = mem[rd_ptr];
    assign p.flit_out_valid = !empty;
    assign p.count          = cnt;

    // XY dimension-order routing: resolve X first, then Y.
    always_comb begin
        p.route_out = 5'b00000;
        if (!empty) begin
            if (head.dx > XC)      p.route_out = 5'b00010;
            else if (head.dx < XC) p.route_out = 5'b00100;
            else if (head.dy > YC) p.route_out = 5'b01000;
            else if (head.dy < YC) p.route_out = 5'b10000;
            else                   p.route_out = 5'b00001;
        end
    end
endmodule

// File: tb/tb_pe_input_port.sv
// Bench for pe_input_port (DEPTH=4, X_ID=Y_ID=1): queue-based reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_pe_input_port;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   credits = 0;

    pe_input_port_if bus ();

    pe_input_port #(.DEPTH(DEPTH), .X_ID(1), .Y_ID(1)) dut (
        .clk (clk),
        .RST (RST),
        .p   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is simply a queue of flits.
    logic [19:0] mq[$];
    bit          m_credit;
    bit          m_ovf;

    function automatic logic [4:0] exp_route(input logic [19:0] f);
        int dx = int'(f[19:18]);
        int dy = int'(f[17:16]);
        if (dx > 1) return 5'b00010;
        if (dx < 1) return 5'b00100;
        if (dy > 1) return 5'b01000;
        if (dy < 1) return 5'b10000;
        return 5'b00001;
    endfunction

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            mq.delete();
            m_credit = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (mq.size() != 0) && (bus.flit_out_ready === 1'b1);
            do_push = (bus.flit_in_valid === 1'b1) && ((mq.size() < DEPTH) || do_pop);
            if (bus.flit_in_valid === 1'b1 && !do_push) m_ovf = 1'b1;
            m_credit = do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(bus.flit_in);
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("model_count", 32'(bus.count), 32'(mq.size()));
        chk("model_valid", 32'(bus.flit_out_valid), 32'(mq.size() != 0));
        chk("model_credit", 32'(bus.credit_out), 32'(m_credit));
        if (mq.size() != 0) begin
            chk("model_flit", 32'(bus.flit_out), 32'(mq[0]));
            chk("model_route", 32'(bus.route_out), 32'(exp_route(mq[0])));
        end else begin
            chk("model_route_empty", 32'(bus.route_out), 32'(0));
        end
`ifdef PE_INPUT_PORT_OVF_DETECT_EN
        chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
        if (bus.credit_out === 1'b1) credits++;
    end

    task automatic cyc(input logic v, input logic [19:0] f, input logic r);
        bus.flit_in_valid  = v;
        bus.flit_in        = f;
        bus.flit_out_ready = r;
        @(negedge clk);
    endtask

    task automatic push(input logic [19:0] f);
        cyc(1'b1, f, 1'b0);
    endtask

    // Pop one flit, checking the head and its route before the edge and the credit after it.
    task automatic pop_exp(input string nm, input logic [19:0] e, input logic [4:0] r);
        bus.flit_in_valid  = 1'b0;
        bus.flit_out_ready = 1'b1;
        #1;
        chk({nm, "_flit"}, 32'(bus.flit_out), 32'(e));
        chk({nm, "_route"}, 32'(bus.route_out), 32'(r));
        @(negedge clk);
        chk({nm, "_credit"}, 32'(bus.credit_out), 32'(1));
    endtask

    initial begin
        int c0;
        bus.flit_in        = '0;
        bus.flit_in_valid  = 1'b0;
        bus.flit_out_ready = 1'b0;
        #1 RST = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'(0));
        chk("rst_valid", 32'(bus.flit_out_valid), 32'(0));
        chk("rst_credit", 32'(bus.credit_out), 32'(0));
        chk("rst_route", 32'(bus.route_out), 32'(0));
        RST = 1'b1;
        @(negedge clk);

        // Single flit to (0,1) from node (1,1): West, no bypass.
        bus.flit_in        = 20'h1ABCD;
        bus.flit_in_valid  = 1'b1;
        bus.flit_out_ready = 1'b0;
        #1 chk("nobypass_valid", 32'(bus.flit_out_valid), 32'(0));
        @(negedge clk);
        chk("west_flit", 32'(bus.flit_out), 32'h1ABCD);
        chk("west_route", 32'(bus.route_out), 32'b00100);
        chk("west_count", 32'(bus.count), 32'(1));
        cyc(1'b0, 20'h0, 1'b1);
        chk("west_pop_count", 32'(bus.count), 32'(0));
        chk("west_pop_credit", 32'(bus.credit_out), 32'(1));
        // Ready while empty: no pop, no credit.
        cyc(1'b0, 20'h0, 1'b1);
        cyc(1'b0, 20'h0, 1'b1);
        chk("empty_ready_credit", 32'(bus.credit_out), 32'(0));

        // Four flits, routes Local/North/South/East, drained back to back.
        push(20'h51111);
        push(20'h62222);
        push(20'h43333);
        push(20'h94444);
        chk("fill4_count", 32'(bus.count), 32'(4));
        c0 = credits;
        pop_exp("rt_local", 20'h51111, 5'b00001);
        pop_exp("rt_north", 20'h62222, 5'b01000);
        pop_exp("rt_south", 20'h43333, 5'b10000);
        pop_exp("rt_east",  20'h94444, 5'b00010);
        chk("drain_count", 32'(bus.count), 32'(0));
        cyc(1'b0, 20'h0, 1'b0);
        chk("drain_credits", 32'(credits - c0), 32'(4));

        // Full with simultaneous push and pop.
        push(20'h0B000);
        push(20'h0B001);
        push(20'h0B002);
        push(20'h0B003);
        c0 = credits;
        cyc(1'b1, 20'h0B004, 1'b1);
        chk("both_count", 32'(bus.count), 32'(4));
        cyc(1'b0, 20'h0, 1'b0);
        chk("both_count_hold", 32'(bus.count), 32'(4));
        chk("both_one_credit", 32'(credits - c0), 32'(1));
        pop_exp("both_o1", 20'h0B001, 5'b00100);
        pop_exp("both_o2", 20'h0B002, 5'b00100);
        pop_exp("both_o3", 20'h0B003, 5'b00100);
        pop_exp("both_o4", 20'h0B004, 5'b00100);

        // Overflow: fifth flit dropped.
        push(20'h5C000);
        push(20'h5C001);
        push(20'h5C002);
        push(20'h5C003);
        push(20'hFC004);
        chk("ovf_count", 32'(bus.count), 32'(4));
`ifdef PE_INPUT_PORT_OVF_DETECT_EN
        chk("ovf_flag", 32'(bus.ovf), 32'(1));
`endif
        pop_exp("ovf_o0", 20'h5C000, 5'b00001);
        pop_exp("ovf_o1", 20'h5C001, 5'b00001);
        pop_exp("ovf_o2", 20'h5C002, 5'b00001);
        pop_exp("ovf_o3", 20'h5C003, 5'b00001);
        cyc(1'b0, 20'h0, 1'b0);
        chk("ovf_empty", 32'(bus.count), 32'(0));

        // Reset mid-operation with count=3 and a credit pending.
        push(20'h1D000);
        push(20'h1D001);
        push(20'h1D002);
        push(20'h1D003);
        cyc(1'b0, 20'h0, 1'b1);
        chk("pre_rst_count", 32'(bus.count), 32'(3));
        #2 RST = 1'b0;
        #1;
        chk("midrst_count", 32'(bus.count), 32'(0));
        chk("midrst_valid", 32'(bus.flit_out_valid), 32'(0));
        chk("midrst_credit", 32'(bus.credit_out), 32'(0));
        @(negedge clk);
        RST = 1'b1;
        c0 = credits;
        bus.flit_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_credits", 32'(credits - c0), 32'(0));
`ifdef PE_INPUT_PORT_OVF_DETECT_EN
        chk("postrst_ovf", 32'(bus.ovf), 32'(0));
`endif

        // Mixed traffic, checked against the model only.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 20'h0, 1'b1);
        chk("final_count", 32'(bus.count), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
